data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/mem_pkg.sv | 18 +
 rtl/ram_sp.sv | 20 ++
 rtl/data_mem_responder.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared constants, FSM encoding and address-range helper for the data memory responder.
package mem_pkg;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_CPU       = 2'd0,
    ST_HOST_IDLE = 2'd1,
    ST_HOST_READ = 2'd2
  } state_t;

  // Any set bit above the implemented range makes the access out of range.
  function automatic logic addr_oor(input logic [15:0] a, input int unsigned aw);
    return (a >> aw) != 16'd0;
  endfunction

endpackage

// File: rtl/ram_sp.sv
// Single-port synchronous read-first RAM; one shared address/data port, no reset on storage.
module ram_sp #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory shared between a processor port and a host debug port; the host owns
// the single RAM port while host_en is high, with out-of-range accesses flagged stickily.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           addr,
  input  logic                  dm_wr,
  input  logic [15:0]           to_mem,
  output logic [DATA_WIDTH-1:0] dm_in,
  input  logic                  host_en,
  input  logic                  host_valid,
  input  logic                  host_we,
  input  logic [15:0]           host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_ready,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_rvalid,
  output logic                  err_oor
);

  state_t state, state_nxt;

  logic                  accept;
  logic [15:0]           acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  acc_we, acc_act, oor, ram_we;
  logic [DATA_WIDTH-1:0] ram_rdata, rd_data;
  logic                  dm_src, rd_zero;
  logic [DATA_WIDTH-1:0] dm_hold, host_hold;
  logic                  unused_to_mem;

  assign unused_to_mem = ^(to_mem >> DATA_WIDTH);

  // Ready is qualified by host_en so a request raised while the host lets go is never accepted.
  assign accept = host_ready && host_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_CPU;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CPU:       if (host_en) state_nxt = ST_HOST_IDLE;
      ST_HOST_IDLE: begin
        if (accept)        state_nxt = host_we ? ST_HOST_IDLE : ST_HOST_READ;
        else if (!host_en) state_nxt = ST_CPU;
      end
      ST_HOST_READ: state_nxt = host_en ? ST_HOST_IDLE : ST_CPU;
      default:      state_nxt = ST_CPU;
    endcase
  end

  always_comb begin
    host_ready  = (state == ST_HOST_IDLE) && host_en;
    host_rvalid = (state == ST_HOST_READ);
  end

  // RAM port mux: the processor drives it in CPU, the host otherwise.
  always_comb begin
    acc_addr  = host_addr;
    acc_wdata = host_wdata;
    acc_we    = 1'b0;
    acc_act   = 1'b0;
    case (state)
      ST_CPU: begin
        acc_addr  = addr;
        acc_wdata = to_mem[DATA_WIDTH-1:0];
        acc_we    = dm_wr;
        acc_act   = 1'b1;
      end
      ST_HOST_IDLE: begin
        acc_we  = accept && host_we;
        acc_act = accept;
      end
      default: ;
    endcase
  end

  assign oor    = addr_oor(acc_addr, ADDR_WIDTH);
  assign ram_we = acc_we && !oor;

  ram_sp #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (acc_addr[ADDR_WIDTH-1:0]),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  // RAM output has no reset; hold registers give the resettable, held views of it.
  assign rd_data    = rd_zero ? '0 : ram_rdata;
  assign dm_in      = dm_src ? rd_data : dm_hold;
  assign host_rdata = host_rvalid ? rd_data : host_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dm_src    <= 1'b0;
      rd_zero   <= 1'b0;
      dm_hold   <= '0;
      host_hold <= '0;
      err_oor   <= 1'b0;
    end else begin
      dm_src    <= (state == ST_CPU);
      rd_zero   <= oor;
      dm_hold   <= dm_in;
      host_hold <= host_rdata;
      if (acc_act && oor) err_oor <= 1'b1;
    end
  end

endmodule
